// File: rtl/password_handler.sv
// -----------------------------------------------------------------------------
// password_handler
//
// Second authentication stage, sitting behind the ID stage. When an ID is
// matched, the player's stored 4-digit hex password is fetched from an
// external synchronous ROM. Four digits are then collected from the switches
// and the enter button, and the login is granted or refused. Repeated wrong
// entries cause a timed lockout. Guest IDs skip the password entirely.
//
// Parameters
//   MAX_ATTEMPTS  wrong entries allowed before lockout (1..3)
//   ROM_LATENCY   cycles from a RomAddress change until RomData is valid (1..7)
//   LOCK_CYCLES   lockout duration in clocks (1..2^26-1)
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous reset, active low
//   MatchedID       high while the ID stage holds a matched ID
//   PlayerAddress   ROM index of the matched player (valid with MatchedID)
//   isGuest         matched ID is the guest ID (valid with MatchedID)
//   PasswordSwitch  current digit value
//   PasswordButton  digit-enter strobe, one-cycle pulse
//   LogoutCommand   logout request, one-cycle pulse
//   RomAddress      password ROM address
//   RomData         stored password, first digit in [15:12]
//   Authenticated   login granted
//   LoginFail       one-cycle pulse per wrong entry
//   LockedOut       lockout active
//   AttemptsLeft    remaining attempts
//   DigitCount      digits entered in the current attempt (0..4)
// -----------------------------------------------------------------------------
module password_handler #(
    parameter int MAX_ATTEMPTS = 3,
    parameter int ROM_LATENCY  = 3,
    parameter int LOCK_CYCLES  = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MatchedID,
    input  logic [4:0]  PlayerAddress,
    input  logic        isGuest,
    input  logic [3:0]  PasswordSwitch,
    input  logic        PasswordButton,
    input  logic        LogoutCommand,
    output logic [4:0]  RomAddress,
    input  logic [15:0] RomData,
    output logic        Authenticated,
    output logic        LoginFail,
    output logic        LockedOut,
    output logic [1:0]  AttemptsLeft,
    output logic [2:0]  DigitCount
);

    localparam logic [1:0]  ATT_MAX   = 2'(MAX_ATTEMPTS);
    localparam logic [2:0]  WAIT_LAST = 3'(ROM_LATENCY - 1);
    localparam logic [25:0] LOCK_LAST = 26'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CAPTURE,
        S_ENTRY,
        S_COMPARE,
        S_AUTH,
        S_LOCKED
    } state_t;

    state_t       state_q;
    logic [4:0]   rom_addr_q;
    logic         auth_q;
    logic         fail_q;
    logic         locked_q;
    logic [1:0]   attempts_q;
    logic [2:0]   digits_q;
    logic [15:0]  stored_q;
    logic [15:0]  entered_q;
    logic [2:0]   wait_cnt_q;
    logic [25:0]  lock_cnt_q;

    logic         abortable;
    logic         abort_req;
    logic [1:0]   attempts_dec;

    // Every state between the fetch and a granted login can be abandoned by
    // a logout or by the ID stage dropping its match. LOCKED and IDLE cannot.
    assign abortable = (state_q == S_WAIT)    || (state_q == S_CAPTURE) ||
                       (state_q == S_ENTRY)   || (state_q == S_COMPARE) ||
                       (state_q == S_AUTH);
    assign abort_req    = LogoutCommand || !MatchedID;
    assign attempts_dec = attempts_q - 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rom_addr_q <= 5'd0;
            auth_q     <= 1'b0;
            fail_q     <= 1'b0;
            locked_q   <= 1'b0;
            attempts_q <= ATT_MAX;
            digits_q   <= 3'd0;
            stored_q   <= 16'd0;
            entered_q  <= 16'd0;
            wait_cnt_q <= 3'd0;
            lock_cnt_q <= 26'd0;
        end else begin
            // LoginFail is a single-cycle pulse; only COMPARE raises it.
            fail_q <= 1'b0;

            // Abort outranks everything, including a same-cycle digit strobe.
            if (abortable && abort_req) begin
                state_q    <= S_IDLE;
                auth_q     <= 1'b0;
                digits_q   <= 3'd0;
                entered_q  <= 16'd0;
                attempts_q <= ATT_MAX;
                rom_addr_q <= 5'd0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (MatchedID) begin
                            if (isGuest) begin
                                state_q <= S_AUTH;
                            end else begin
                                rom_addr_q <= PlayerAddress;
                                wait_cnt_q <= 3'd0;
                                state_q    <= S_WAIT;
                            end
                        end
                    end

                    // Hold off until the ROM output reflects the new address.
                    S_WAIT: begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_q <= S_CAPTURE;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 3'd1;
                        end
                    end

                    S_CAPTURE: begin
                        stored_q  <= RomData;
                        entered_q <= 16'd0;
                        digits_q  <= 3'd0;
                        state_q   <= S_ENTRY;
                    end

                    // Digits shift in from the right so the first one entered
                    // ends up in [15:12], matching the ROM layout.
                    S_ENTRY: begin
                        if (PasswordButton) begin
                            entered_q <= {entered_q[11:0], PasswordSwitch};
                            digits_q  <= digits_q + 3'd1;
                            if (digits_q == 3'd3) begin
                                state_q <= S_COMPARE;
                            end
                        end
                    end

                    S_COMPARE: begin
                        if (entered_q == stored_q) begin
                            auth_q     <= 1'b1;
                            attempts_q <= ATT_MAX;
                            state_q    <= S_AUTH;
                        end else begin
                            fail_q     <= 1'b1;
                            attempts_q <= attempts_dec;
                            digits_q   <= 3'd0;
                            entered_q  <= 16'd0;
                            if (attempts_dec == 2'd0) begin
                                locked_q   <= 1'b1;
                                lock_cnt_q <= 26'd0;
                                state_q    <= S_LOCKED;
                            end else begin
                                state_q <= S_ENTRY;
                            end
                        end
                    end

                    S_AUTH: begin
                        auth_q     <= 1'b1;
                        attempts_q <= ATT_MAX;
                    end

                    // Only the timer (or reset) releases the lockout; inputs
                    // are deliberately not looked at here.
                    S_LOCKED: begin
                        if (lock_cnt_q == LOCK_LAST) begin
                            locked_q   <= 1'b0;
                            attempts_q <= ATT_MAX;
                            state_q    <= S_IDLE;
                        end else begin
                            lock_cnt_q <= lock_cnt_q + 26'd1;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign RomAddress    = rom_addr_q;
    assign Authenticated = auth_q;
    assign LoginFail     = fail_q;
    assign LockedOut     = locked_q;
    assign AttemptsLeft  = attempts_q;
    assign DigitCount    = digits_q;

endmodule
